if_stage: RTL and testbench

- Instruction-fetch stage of the in-order RV32 pipeline.
- Owns the PC, issues single-outstanding requests to instruction memory over a req/gnt + rvalid interface, and handles branch/jump redirects.
- Presents {if_instr, if_pc, if_valid} to the IF/ID pipeline register. A 1-entry skid buffer absorbs a response that arrives while the pipeline is stalled.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_stage_if.sv | 18 +
 rtl/if_stage_skid_buf.sv | 42 ++++
 rtl/if_stage.sv | 153 +++++++++++++++
 tb/tb_if_stage.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_pkg                                                       |
// | Brief  : Shared types and constants for the instruction-fetch stage.  |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package if_pkg;

  // addi x0,x0,0: harmless filler whenever the output slot is empty
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Instruction addresses are always word aligned; drop the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_stage_if                                                  |
// | Brief  : Instruction-memory req/gnt + rvalid bus.                     |
// |          master = fetch stage, slave = instruction memory.            |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface
`default_nettype wire

// File: rtl/if_stage_skid_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_skid_buf                                                  |
// | Brief  : One-entry holding buffer for a fetched packet that arrives   |
// |          while the output slot cannot take it. Flush empties it.      |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module if_skid_buf
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  input  logic       out_ready
);

  logic in_ready;

  // A simultaneous pop frees the entry for the incoming packet.
  assign in_ready = !out_valid || out_ready;

  // Hold one packet; flush wins over load and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_pkt   <= in_pkt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : if_stage                                                     |
// | Brief  : RV32 instruction-fetch stage. Owns the PC, issues single-    |
// |          outstanding fetches, handles redirects and kills, and feeds  |
// |          the IF/ID register through a registered slot + 1-entry skid. |
// |          Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt and    |
// |          perf_kill_cnt outputs.                                       |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         kill;

  logic         slot_valid;
  fetch_pkt_t   slot_pkt;
  logic         skid_valid;
  fetch_pkt_t   skid_pkt;

  logic         fire;
  logic         rsp;
  logic         deliver;
  logic         discard;
  logic         consume;
  logic         skid_push;
  logic         skid_pop;
  fetch_pkt_t   rsp_pkt;

  // A new request waits for the skid to drain so at most two packets are held.
  assign imem.req  = !rst && (state == FETCH) && !skid_valid && !redirect;
  assign imem.addr = pc;

  assign fire    = imem.req && imem.gnt;
  assign rsp     = (state == WAIT) && imem.rvalid;
  assign deliver = rsp && !kill && !redirect;
  assign discard = rsp && (kill || redirect);
  assign consume = slot_valid && !stall;
  assign rsp_pkt = '{instr: imem.rdata, pc: req_pc};

  // The skid only takes data the slot cannot; it refills the slot on consume.
  assign skid_push = deliver && slot_valid && (!consume || skid_valid);
  assign skid_pop  = consume && skid_valid;

  if_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .in_valid  (skid_push),
    .in_pkt    (rsp_pkt),
    .out_valid (skid_valid),
    .out_pkt   (skid_pkt),
    .out_ready (skid_pop)
  );

  // PC, request/response FSM and kill tracking; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            kill  <= 1'b0;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
      if (redirect) begin
        pc <= word_align(redirect_pc);
        // A response still in flight belongs to the old path.
        if ((state == WAIT) && !imem.rvalid) begin
          kill <= 1'b1;
        end
      end
    end
  end

  // Output slot: skid has priority over fresh data to keep program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_pkt   <= '{instr: NOP_INSTR, pc: 32'h0};
    end else if (redirect) begin
      slot_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        slot_valid <= 1'b1;
        slot_pkt   <= skid_pkt;
      end else if (deliver) begin
        slot_valid <= 1'b1;
        slot_pkt   <= rsp_pkt;
      end else begin
        slot_valid <= 1'b0;
      end
    end else if (deliver && !slot_valid) begin
      slot_valid <= 1'b1;
      slot_pkt   <= rsp_pkt;
    end
  end

  assign if_valid = slot_valid;
  assign if_pc    = slot_pkt.pc;
  assign if_instr = slot_valid ? slot_pkt.instr : NOP_INSTR;

`ifdef IF_PERF_CNT_EN
  // Count delivered and discarded responses; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (deliver) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (discard) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_if_stage                                                  |
// | Brief  : Randomized scoreboard bench for if_stage, plus a second      |
// |          instance exercising PC wrap and asynchronous reset.          |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_instr, if_pc;
  logic        if_valid;
  if_stage_if  imem ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_cnt, pk_cnt;
`endif

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (pf_cnt),
    .perf_kill_cnt  (pk_cnt)
`endif
  );

  // Second instance: PC wrap and async reset, ideal 0-wait memory.
  logic        rst2 = 1'b1;
  logic [31:0] i2, p2;
  logic        v2;
  if_stage_if  m2 ();

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem        (m2),
    .if_instr    (i2),
    .if_pc       (p2),
    .if_valid    (v2)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (),
    .perf_kill_cnt  ()
`endif
  );

  always #5 clk = ~clk;

  // Memory image: every word address has a distinct pseudo-random instruction.
  function automatic logic [31:0] image(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign m2.gnt = m2.req;
  always @(posedge clk or posedge rst2) begin
    if (rst2) begin
      m2.rvalid <= 1'b0;
      m2.rdata  <= 32'h0;
    end else begin
      m2.rvalid <= m2.req && m2.gnt;
      m2.rdata  <= image(m2.addr);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: expected in-order instruction stream
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t expq[$];

  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    expq.delete();
    p = start;
    for (int i = 0; i < 2000; i++) begin
      expq.push_back('{pc: p, instr: image(p)});
      p = p + 32'd4;
    end
  endtask

  // ---------------- stimulus + memory model
  int          gnt_wait_max = 0, rsp_delay_max = 0, stall_pct = 0, redir_pm = 0;
  bit          spur_en = 0, force_redir = 0;
  int          fidx = -1;
  bit          pending = 0, pend_redir = 0;
  logic [31:0] pend_addr;
  int          pend_delay = 0, gwait = 0;
  int          model_fetch = 0, model_kill = 0;
  logic [31:0] gaddr[$];

  always @(negedge clk) begin
    if (rst) begin
      pending     = 0;
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b0;
      imem.rdata  = 32'h0;
      redirect    = 1'b0;
      stall       = 1'b0;
      gwait       = 0;
    end else begin
      stall    = ($urandom_range(99) < stall_pct);
      redirect = 1'b0;
      if (force_redir && pending && pend_delay > 0) begin
        force_redir = 0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        fidx        = gaddr.size();
        refill(32'h0000_0100);
      end else if (redir_pm > 0 && $urandom_range(999) < redir_pm) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        refill(redirect_pc & 32'hFFFF_FFFC);
      end
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b0;
      if (pending) begin
        if (redirect) pend_redir = 1;
        if (pend_delay == 0) begin
          imem.rvalid = 1'b1;
          imem.rdata  = image(pend_addr);
          pending     = 0;
          if (pend_redir) model_kill++;
          else model_fetch++;
        end else begin
          pend_delay--;
        end
      end else if (spur_en && $urandom_range(9) == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hBAD0_0000 | ($urandom & 32'hFFFF);
      end
      #1;
      if (imem.req) begin
        if (gwait == 0) begin
          imem.gnt   = 1'b1;
          pending    = 1;
          pend_addr  = imem.addr;
          pend_redir = 0;
          pend_delay = $urandom_range(rsp_delay_max);
          gwait      = $urandom_range(gnt_wait_max);
        end else begin
          gwait--;
        end
      end
    end
  end

  // ---------------- monitor: samples two time units before each rising edge
  int          cyc = 0, ncons = 0, first_gnt_cyc = -1, first_valid_cyc = -1;
  int          cons_cyc[$];
  bit          prev_hold = 0;
  logic [31:0] prev_addr = 32'h0;

  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      cyc++;
      if (imem.req) begin
        check("addr_aligned", {30'h0, imem.addr[1:0]}, 32'h0);
        if (prev_hold) check("addr_stable", imem.addr, prev_addr);
        if (imem.gnt) begin
          if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
          gaddr.push_back(imem.addr);
        end
      end
      prev_hold = imem.req && !imem.gnt;
      prev_addr = imem.addr;
      if (!if_valid) check("nop_when_invalid", if_instr, IF_NOP_INSTR);
      if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (if_valid && !stall && !redirect) begin
        if (expq.size() == 0) begin
          check("scoreboard_underflow", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_instr", if_instr, e.instr);
          ncons++;
          cons_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- sequencing
  initial begin
    int  nreq;
    bit  seen;
    // Wrap instance: first fetch at 0xFFFF_FFFC, next address wraps to 0.
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst2 = 1'b0;
    nreq = 0;
    seen = 0;
    for (int c = 0; c < 30 && !(seen && nreq >= 2); c++) begin
      @(negedge clk);
      #3;
      if (m2.req) begin
        nreq++;
        if (nreq == 2) check("wrap_next_addr", m2.addr, 32'h0000_0000);
      end
      if (v2 && !seen) begin
        seen = 1;
        check("wrap_first_pc", p2, 32'hFFFF_FFFC);
        check("wrap_first_instr", i2, image(32'hFFFF_FFFC));
      end
    end
    if (!seen || nreq < 2) check("wrap_timeout", 32'h1, 32'h0);
    // Async reset while waiting on a response.
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #3;
      if (m2.req) seen = 1;
    end
    @(posedge clk);
    #2 rst2 = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, v2}, 32'h0);
    check("async_rst_pc", m2.addr, 32'hFFFF_FFFC);
    check("async_rst_req", {31'h0, m2.req}, 32'h0);

    // Main instance reset state.
    #1;
    check("reset_valid", {31'h0, if_valid}, 32'h0);
    check("reset_instr", if_instr, IF_NOP_INSTR);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_req", {31'h0, imem.req}, 32'h0);

    // Phase 1: ideal memory, no stalls.
    refill(32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (24) @(negedge clk);
    #4;
    if (gaddr.size() >= 3) begin
      check("addr_seq0", gaddr[0], 32'h0);
      check("addr_seq1", gaddr[1], 32'h4);
      check("addr_seq2", gaddr[2], 32'h8);
    end else check("addr_seq_count", gaddr.size(), 3);
    if (cons_cyc.size() >= 3) begin
      check("throughput01", cons_cyc[1] - cons_cyc[0], 2);
      check("throughput12", cons_cyc[2] - cons_cyc[1], 2);
    end else check("cons_count", cons_cyc.size(), 3);
    check("latency", first_valid_cyc - first_gnt_cyc, 2);

    // Phase 2: grant delays, response delays, heavy stalls.
    gnt_wait_max  = 3;
    rsp_delay_max = 3;
    stall_pct     = 45;
    repeat (400) @(negedge clk);

    // Phase 3: redirect in WAIT, then random redirects and stray rvalids.
    gnt_wait_max  = 0;
    rsp_delay_max = 2;
    stall_pct     = 30;
    force_redir   = 1;
    for (int c = 0; c < 200 && force_redir; c++) @(negedge clk);
    if (force_redir) check("force_redirect_timeout", 32'h1, 32'h0);
    repeat (20) @(negedge clk);
    if (fidx >= 0 && gaddr.size() > fidx) check("redirect_target", gaddr[fidx], 32'h0000_0100);
    else check("redirect_grant_missing", 32'h1, 32'h0);
    gnt_wait_max  = 2;
    rsp_delay_max = 3;
    redir_pm      = 15;
    spur_en       = 1;
    repeat (2000) @(negedge clk);

    // Drain and compare counters.
    redir_pm  = 0;
    spur_en   = 0;
    stall_pct = 0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    check("enough_deliveries", {31'h0, ncons > 200}, 32'h1);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_cnt", pf_cnt, model_fetch);
    check("perf_kill_cnt", pk_cnt, model_kill);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
